// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared types and defaults for the FPU issue/scoreboard/writeback controller.
package fpu_issue_ctrl_pkg;

    // Register file bank selector, shared with the decode stage.
    typedef enum logic {
        X_REG = 1'b0,
        F_REG = 1'b1
    } reg_bank_mux_t;

    localparam int FPU_DEPTH_DEFAULT        = 4;
    localparam int FPU_STARVE_LIMIT_DEFAULT = 4;
    localparam int FPU_TAG_W_DEFAULT        = $clog2(FPU_DEPTH_DEFAULT);

    typedef logic [FPU_TAG_W_DEFAULT-1:0] fpu_tag_t;

    // One in-flight FPU op: the destination it will eventually write.
    typedef struct packed {
        logic          valid;
        logic [4:0]    rd_addr;
        reg_bank_mux_t rd_bank;
    } fpu_slot_t;

    // Register identity compare; x0 in the integer bank is hardwired zero
    // and so can never create a dependency.
    function automatic logic reg_match(
        input logic [4:0] a_addr,
        input logic       a_bank,
        input logic [4:0] b_addr,
        input logic       b_bank
    );
        return (a_addr == b_addr) && (a_bank == b_bank) &&
               !((a_bank == X_REG) && (a_addr == 5'd0));
    endfunction

endpackage

// File: rtl/fpu_slot_table.sv
// In-flight FPU op table: allocation of free tags, set on issue, clear on
// writeback, lookup by returning tag, and the parallel hazard match against ID.
module fpu_slot_table
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = FPU_DEPTH_DEFAULT,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    // set on issue
    input  logic             i_set_en,
    input  logic [TAG_W-1:0] i_set_idx,
    input  logic [4:0]       i_set_rd_addr,
    input  logic             i_set_rd_bank,
    // clear on writeback
    input  logic             i_clr_en,
    input  logic [TAG_W-1:0] i_clr_idx,
    // lookup by returning tag
    input  logic [TAG_W-1:0] i_look_idx,
    output logic             o_look_valid,
    output logic [4:0]       o_look_rd_addr,
    output logic             o_look_rd_bank,
    // hazard query from ID
    input  logic [2:0]       i_rs_valid,
    input  logic [14:0]      i_rs_addr,
    input  logic [2:0]       i_rs_bank,
    input  logic             i_rd_valid,
    input  logic [4:0]       i_rd_addr,
    input  logic             i_rd_bank,
    output logic             o_hit,
    // allocation status
    output logic [TAG_W-1:0] o_alloc,
    output logic             o_full,
    output logic             o_any_valid
);

    fpu_slot_t        w_slot [DEPTH];
    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_match;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        fpu_slot_t r_slot;

        // Slot register: issue writes it, writeback invalidates it.
        // Set and clear never target the same slot since alloc only picks invalid ones.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_slot <= '0;
            end else if (i_set_en && (i_set_idx == TAG_W'(gi))) begin
                r_slot.valid   <= 1'b1;
                r_slot.rd_addr <= i_set_rd_addr;
                r_slot.rd_bank <= reg_bank_mux_t'(i_set_rd_bank);
            end else if (i_clr_en && (i_clr_idx == TAG_W'(gi))) begin
                r_slot.valid <= 1'b0;
            end
        end

        assign w_slot[gi]  = r_slot;
        assign w_valid[gi] = r_slot.valid;

        // RAW on any used source or WAW on rd against this slot's destination.
        assign w_match[gi] = r_slot.valid & (
            (i_rs_valid[0] & reg_match(i_rs_addr[4:0],   i_rs_bank[0], r_slot.rd_addr, r_slot.rd_bank)) |
            (i_rs_valid[1] & reg_match(i_rs_addr[9:5],   i_rs_bank[1], r_slot.rd_addr, r_slot.rd_bank)) |
            (i_rs_valid[2] & reg_match(i_rs_addr[14:10], i_rs_bank[2], r_slot.rd_addr, r_slot.rd_bank)) |
            (i_rd_valid    & reg_match(i_rd_addr,        i_rd_bank,    r_slot.rd_addr, r_slot.rd_bank)));
    end

    // Lowest-index free slot; scanning downward leaves the lowest one last.
    always_comb begin
        o_alloc = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!w_valid[i]) begin
                o_alloc = TAG_W'(i);
            end
        end
    end

    assign o_full      = &w_valid;
    assign o_any_valid = |w_valid;
    assign o_hit       = |w_match;

    assign o_look_valid   = w_slot[i_look_idx].valid;
    assign o_look_rd_addr = w_slot[i_look_idx].rd_addr;
    assign o_look_rd_bank = w_slot[i_look_idx].rd_bank;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: grants FPU ops from ID with a free tag, stalls ID on
// hazards against in-flight destinations, buffers one returning result and
// arbitrates it onto the shared writeback port behind the ALU/MEM pipeline.
module fpu_issue_ctrl
    import fpu_issue_ctrl_pkg::*;
#(
    parameter  int DEPTH        = FPU_DEPTH_DEFAULT,
    parameter  int STARVE_LIMIT = FPU_STARVE_LIMIT_DEFAULT,
    localparam int TAG_W        = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [2:0]       id_rs_valid_i,
    input  logic [14:0]      id_rs_addr_i,
    input  logic [2:0]       id_rs_bank_i,
    input  logic             id_rd_valid_i,
    input  logic [4:0]       id_rd_addr_i,
    input  logic             id_rd_bank_i,
    input  logic             issue_req_i,
    input  logic             flush_i,
    output logic             issue_gnt_o,
    output logic             hazard_stall_o,
    output logic             fpu_req_o,
    output logic [TAG_W-1:0] fpu_tag_o,
    input  logic             fpu_gnt_i,
    input  logic             fpu_rvalid_i,
    input  logic [TAG_W-1:0] fpu_tag_i,
    input  logic [31:0]      fpu_result_i,
    input  logic [4:0]       fpu_flags_i,
    output logic             fpu_ready_o,
    input  logic             wb_alu_valid_i,
    output logic             wb_fpu_valid_o,
    output logic [4:0]       wb_fpu_addr_o,
    output logic             wb_fpu_bank_o,
    output logic [31:0]      wb_fpu_data_o,
    output logic [4:0]       wb_fpu_flags_o,
    output logic             wb_stall_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    // hold buffer: one captured FPU result waiting for the writeback port
    logic             r_hold_v;
    logic [31:0]      r_hold_data;
    logic [4:0]       r_hold_flags;
    logic [4:0]       r_hold_rd_addr;
    logic             r_hold_rd_bank;
    logic [TAG_W-1:0] r_hold_tag;

    // starvation tracking
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_wb_stall;

    logic             w_tbl_hit;
    logic             w_hold_hit;
    logic             w_hit;
    logic             w_full;
    logic             w_any_valid;
    logic [TAG_W-1:0] w_alloc;
    logic             w_look_valid;
    logic [4:0]       w_look_rd_addr;
    logic             w_look_rd_bank;
    logic             w_fpu_req;
    logic             w_issue_gnt;
    logic             w_wb_fire;
    logic             w_fpu_ready;
    logic             w_capture;
    logic             w_busy;

    fpu_slot_table #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_slot_table (
        .i_clk          (clk_i),
        .i_rst          (rst_i),
        .i_set_en       (w_issue_gnt),
        .i_set_idx      (w_alloc),
        .i_set_rd_addr  (id_rd_addr_i),
        .i_set_rd_bank  (id_rd_bank_i),
        .i_clr_en       (w_wb_fire),
        .i_clr_idx      (r_hold_tag),
        .i_look_idx     (fpu_tag_i),
        .o_look_valid   (w_look_valid),
        .o_look_rd_addr (w_look_rd_addr),
        .o_look_rd_bank (w_look_rd_bank),
        .i_rs_valid     (id_rs_valid_i),
        .i_rs_addr      (id_rs_addr_i),
        .i_rs_bank      (id_rs_bank_i),
        .i_rd_valid     (id_rd_valid_i),
        .i_rd_addr      (id_rd_addr_i),
        .i_rd_bank      (id_rd_bank_i),
        .o_hit          (w_tbl_hit),
        .o_alloc        (w_alloc),
        .o_full         (w_full),
        .o_any_valid    (w_any_valid)
    );

    // The hold buffer's slot is still valid, but it is matched directly too so
    // the hazard view never depends on slot/hold bookkeeping staying in step.
    assign w_hold_hit = r_hold_v & (
        (id_rs_valid_i[0] & reg_match(id_rs_addr_i[4:0],   id_rs_bank_i[0], r_hold_rd_addr, r_hold_rd_bank)) |
        (id_rs_valid_i[1] & reg_match(id_rs_addr_i[9:5],   id_rs_bank_i[1], r_hold_rd_addr, r_hold_rd_bank)) |
        (id_rs_valid_i[2] & reg_match(id_rs_addr_i[14:10], id_rs_bank_i[2], r_hold_rd_addr, r_hold_rd_bank)) |
        (id_rd_valid_i    & reg_match(id_rd_addr_i,        id_rd_bank_i,    r_hold_rd_addr, r_hold_rd_bank)));

    assign w_hit = w_tbl_hit | w_hold_hit;

    // Input-driven outputs are forced low while reset is held so that every
    // output reads 0 during reset, not only the registered ones.
    assign w_fpu_req   = ~rst_i & issue_req_i & id_valid_i & ~w_hit & ~w_full & ~flush_i;
    assign w_issue_gnt = w_fpu_req & fpu_gnt_i;

    assign w_wb_fire   = r_hold_v & ~wb_alu_valid_i;
    assign w_fpu_ready = ~rst_i & (~r_hold_v | w_wb_fire);

    // Returns whose tag names no live slot are dropped (stale after reset).
    assign w_capture = fpu_rvalid_i & w_fpu_ready & w_look_valid;
    assign w_busy    = w_any_valid | r_hold_v;

    assign issue_gnt_o    = w_issue_gnt;
    assign fpu_req_o      = w_fpu_req;
    assign fpu_tag_o      = w_alloc;
    assign hazard_stall_o = ~rst_i & id_valid_i & (w_hit | (issue_req_i & w_full));
    assign fpu_ready_o    = w_fpu_ready;

    assign wb_fpu_valid_o = w_wb_fire;
    assign wb_fpu_addr_o  = w_wb_fire ? r_hold_rd_addr : 5'd0;
    assign wb_fpu_bank_o  = w_wb_fire ? r_hold_rd_bank : 1'b0;
    assign wb_fpu_data_o  = w_wb_fire ? r_hold_data    : 32'd0;
    assign wb_fpu_flags_o = w_wb_fire ? r_hold_flags   : 5'd0;
    assign wb_stall_o     = r_wb_stall;
    assign busy_o         = w_busy;

    // Hold buffer: capture a result (possibly in the same cycle the old one drains).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hold_v       <= 1'b0;
            r_hold_data    <= '0;
            r_hold_flags   <= '0;
            r_hold_rd_addr <= '0;
            r_hold_rd_bank <= 1'b0;
            r_hold_tag     <= '0;
        end else if (w_capture) begin
            r_hold_v       <= 1'b1;
            r_hold_data    <= fpu_result_i;
            r_hold_flags   <= fpu_flags_i;
            r_hold_rd_addr <= w_look_rd_addr;
            r_hold_rd_bank <= w_look_rd_bank;
            r_hold_tag     <= fpu_tag_i;
        end else if (w_wb_fire) begin
            r_hold_v <= 1'b0;
        end
    end

    // Starvation counter: count lost arbitrations, raise wb_stall_o on the
    // edge the count reaches the limit, and drop both once the result drains.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_starve_cnt <= '0;
            r_wb_stall   <= 1'b0;
        end else if (w_wb_fire) begin
            r_starve_cnt <= '0;
            r_wb_stall   <= 1'b0;
        end else if (r_hold_v && wb_alu_valid_i) begin
            if (r_starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
            if (r_starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
                r_wb_stall <= 1'b1;
            end
        end
    end

    // A return naming a dead slot while ops are in flight is a protocol error;
    // with nothing in flight it is taken to be a stale return after reset.
    a_rvalid_tag_live: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (fpu_rvalid_i && w_fpu_ready && w_busy) |-> w_look_valid
    );

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a writeback scoreboard.
module tb_fpu_issue_ctrl;
    import fpu_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_rs_valid;
    logic [14:0] id_rs_addr;
    logic [2:0]  id_rs_bank;
    logic        id_rd_valid;
    logic [4:0]  id_rd_addr;
    logic        id_rd_bank;
    logic        issue_req;
    logic        flush;
    logic        issue_gnt;
    logic        hazard_stall;
    logic        fpu_req;
    logic [1:0]  fpu_tag_out;
    logic        fpu_gnt;
    logic        fpu_rvalid;
    logic [1:0]  fpu_tag_in;
    logic [31:0] fpu_result;
    logic [4:0]  fpu_flags;
    logic        fpu_ready;
    logic        wb_alu_valid;
    logic        wb_fpu_valid;
    logic [4:0]  wb_fpu_addr;
    logic        wb_fpu_bank;
    logic [31:0] wb_fpu_data;
    logic [4:0]  wb_fpu_flags;
    logic        wb_stall;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [4:0]  addr;
        logic        bank;
        logic [31:0] data;
        logic [4:0]  flags;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    wb_exp_t mon_e;

    fpu_issue_ctrl #(
        .DEPTH        (4),
        .STARVE_LIMIT (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .id_valid_i     (id_valid),
        .id_rs_valid_i  (id_rs_valid),
        .id_rs_addr_i   (id_rs_addr),
        .id_rs_bank_i   (id_rs_bank),
        .id_rd_valid_i  (id_rd_valid),
        .id_rd_addr_i   (id_rd_addr),
        .id_rd_bank_i   (id_rd_bank),
        .issue_req_i    (issue_req),
        .flush_i        (flush),
        .issue_gnt_o    (issue_gnt),
        .hazard_stall_o (hazard_stall),
        .fpu_req_o      (fpu_req),
        .fpu_tag_o      (fpu_tag_out),
        .fpu_gnt_i      (fpu_gnt),
        .fpu_rvalid_i   (fpu_rvalid),
        .fpu_tag_i      (fpu_tag_in),
        .fpu_result_i   (fpu_result),
        .fpu_flags_i    (fpu_flags),
        .fpu_ready_o    (fpu_ready),
        .wb_alu_valid_i (wb_alu_valid),
        .wb_fpu_valid_o (wb_fpu_valid),
        .wb_fpu_addr_o  (wb_fpu_addr),
        .wb_fpu_bank_o  (wb_fpu_bank),
        .wb_fpu_data_o  (wb_fpu_data),
        .wb_fpu_flags_o (wb_fpu_flags),
        .wb_stall_o     (wb_stall),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Writeback monitor: every written-back result must be the oldest expected one.
    always @(negedge clk) begin
        if (rst === 1'b0 && wb_fpu_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wb_unexpected: got addr=%0d bank=%0d data=0x%0h, expected no writeback",
                         wb_fpu_addr, wb_fpu_bank, wb_fpu_data);
            end else begin
                mon_e = exp_q.pop_front();
                $display("wb   addr=%0d bank=%0d data=0x%0h flags=0x%0h", wb_fpu_addr, wb_fpu_bank,
                         wb_fpu_data, wb_fpu_flags);
                chk("wb_addr",  32'(wb_fpu_addr),  32'(mon_e.addr));
                chk("wb_bank",  32'(wb_fpu_bank),  32'(mon_e.bank));
                chk("wb_data",  wb_fpu_data,       mon_e.data);
                chk("wb_flags", 32'(wb_fpu_flags), 32'(mon_e.flags));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid     = 1'b0;
        id_rs_valid  = 3'b000;
        id_rs_addr   = 15'd0;
        id_rs_bank   = 3'b000;
        id_rd_valid  = 1'b0;
        id_rd_addr   = 5'd0;
        id_rd_bank   = 1'b0;
        issue_req    = 1'b0;
        flush        = 1'b0;
        fpu_gnt      = 1'b1;
        fpu_rvalid   = 1'b0;
        fpu_tag_in   = 2'd0;
        fpu_result   = 32'd0;
        fpu_flags    = 5'd0;
        wb_alu_valid = 1'b0;
    endtask

    // One-cycle FPU issue that must be granted with the given tag.
    task automatic issue(input logic [4:0] rd, input logic bank, input int exp_tag);
        id_valid    = 1'b1;
        issue_req   = 1'b1;
        id_rd_valid = 1'b1;
        id_rd_addr  = rd;
        id_rd_bank  = bank;
        #1;
        $display("iss  rd=%0d bank=%0d tag=%0d", rd, bank, fpu_tag_out);
        chk("issue_req", 32'(fpu_req),     1);
        chk("issue_tag", 32'(fpu_tag_out), 32'(exp_tag));
        chk("issue_gnt", 32'(issue_gnt),   1);
        tick();
        idle();
    endtask

    // One-cycle FPU return; the expected writeback is queued for the monitor.
    task automatic ret(input logic [1:0] tag, input logic [31:0] data, input logic [4:0] flags,
                       input logic [4:0] exp_rd, input logic exp_bank);
        wb_exp_t e;
        fpu_rvalid = 1'b1;
        fpu_tag_in = tag;
        fpu_result = data;
        fpu_flags  = flags;
        e.addr  = exp_rd;
        e.bank  = exp_bank;
        e.data  = data;
        e.flags = flags;
        exp_q.push_back(e);
        #1;
        $display("ret  tag=%0d data=0x%0h flags=0x%0h", tag, data, flags);
        chk("ret_ready", 32'(fpu_ready), 1);
        tick();
        fpu_rvalid = 1'b0;
        fpu_result = 32'd0;
        fpu_flags  = 5'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;
        // reset: an active request must not leak through
        id_valid  = 1'b1;
        issue_req = 1'b1;
        repeat (2) tick();
        chk("rst_fpu_req",   32'(fpu_req),      0);
        chk("rst_issue_gnt", 32'(issue_gnt),    0);
        chk("rst_hazard",    32'(hazard_stall), 0);
        chk("rst_ready",     32'(fpu_ready),    0);
        chk("rst_wb_valid",  32'(wb_fpu_valid), 0);
        chk("rst_wb_stall",  32'(wb_stall),     0);
        chk("rst_busy",      32'(busy),         0);
        idle();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(fpu_ready), 1);

        // 1: RAW on f3 stalls until its writeback cycle
        issue(5'd3, F_REG, 0);
        id_valid    = 1'b1;
        id_rs_valid = 3'b001;
        id_rs_addr  = 15'd3;
        id_rs_bank  = 3'b000;
        #1;
        chk("raw_x3_no_hazard", 32'(hazard_stall), 0);
        id_rs_bank = 3'b001;
        #1;
        chk("raw_f3_hazard", 32'(hazard_stall), 1);
        tick();
        chk("raw_f3_hazard_hold", 32'(hazard_stall), 1);
        ret(2'd0, 32'h40490FDB, 5'b00001, 5'd3, F_REG);
        #1;
        chk("raw_wb_cycle_valid",  32'(wb_fpu_valid), 1);
        chk("raw_wb_cycle_hazard", 32'(hazard_stall), 1);
        tick();
        chk("raw_after_wb_hazard", 32'(hazard_stall), 0);
        chk("raw_after_wb_busy",   32'(busy),         0);
        idle();

        // 2: fill the table, 5th request stalls, freed slot reused
        issue(5'd10, F_REG, 0);
        issue(5'd11, F_REG, 1);
        issue(5'd12, F_REG, 2);
        issue(5'd13, F_REG, 3);
        id_valid    = 1'b1;
        id_rd_valid = 1'b1;
        id_rd_addr  = 5'd11;
        id_rd_bank  = F_REG;
        #1;
        chk("waw_f11_hazard", 32'(hazard_stall), 1);
        id_rd_addr = 5'd14;
        issue_req  = 1'b1;
        #1;
        chk("full_fpu_req", 32'(fpu_req),      0);
        chk("full_hazard",  32'(hazard_stall), 1);
        chk("full_gnt",     32'(issue_gnt),    0);
        ret(2'd1, 32'h12345678, 5'b00000, 5'd11, F_REG);
        #1;
        chk("full_wb_cycle_req", 32'(fpu_req), 0);
        tick();
        chk("reuse_req", 32'(fpu_req),     1);
        chk("reuse_tag", 32'(fpu_tag_out), 1);
        chk("reuse_gnt", 32'(issue_gnt),   1);
        tick();
        idle();
        // slots now: 0=f10 1=f14 2=f12 3=f13

        // 4: out-of-order returns, back-to-back through the hold buffer
        ret(2'd2, 32'h3F800000, 5'b10000, 5'd12, F_REG);
        ret(2'd0, 32'h3F800000, 5'b00011, 5'd10, F_REG);
        tick();

        // 3: starvation behind the ALU pipeline
        wb_alu_valid = 1'b1;
        ret(2'd3, 32'hC0000000, 5'b00100, 5'd13, F_REG);
        for (int c = 1; c <= 6; c++) begin
            #1;
            chk($sformatf("starve_c%0d_stall", c), 32'(wb_stall), (c >= 5) ? 1 : 0);
            if (c == 1) begin
                chk("starve_ready", 32'(fpu_ready), 0);
            end
            tick();
        end
        wb_alu_valid = 1'b0;
        #1;
        chk("starve_fire_valid", 32'(wb_fpu_valid), 1);
        chk("starve_fire_stall", 32'(wb_stall),     1);
        tick();
        chk("starve_cleared", 32'(wb_stall), 0);
        ret(2'd1, 32'h00000001, 5'b01000, 5'd14, F_REG);
        tick();
        chk("drained_busy", 32'(busy), 0);

        // 5: flush suppresses only the current request
        id_valid    = 1'b1;
        issue_req   = 1'b1;
        id_rd_valid = 1'b1;
        id_rd_addr  = 5'd5;
        id_rd_bank  = F_REG;
        flush       = 1'b1;
        #1;
        chk("flush_req", 32'(fpu_req),   0);
        chk("flush_gnt", 32'(issue_gnt), 0);
        tick();
        idle();
        #1;
        chk("flush_no_slot", 32'(busy), 0);
        issue(5'd6, F_REG, 0);
        id_valid    = 1'b1;
        issue_req   = 1'b1;
        id_rd_valid = 1'b1;
        id_rd_addr  = 5'd7;
        id_rd_bank  = F_REG;
        flush       = 1'b1;
        #1;
        chk("flush2_req", 32'(fpu_req), 0);
        tick();
        idle();
        #1;
        chk("flush2_alloc", 32'(fpu_tag_out), 1);
        ret(2'd0, 32'hDEADBEEF, 5'b11111, 5'd6, F_REG);
        tick();
        chk("flush_inflight_done", 32'(busy), 0);

        // x0 as destination never creates a dependency
        issue(5'd0, X_REG, 0);
        id_valid    = 1'b1;
        id_rs_valid = 3'b010;
        id_rs_addr  = 15'd0;
        id_rs_bank  = 3'b000;
        id_rd_valid = 1'b1;
        id_rd_addr  = 5'd0;
        id_rd_bank  = X_REG;
        #1;
        chk("x0_no_hazard", 32'(hazard_stall), 0);
        idle();
        ret(2'd0, 32'h00000055, 5'b00000, 5'd0, X_REG);
        tick();

        // 6: reset with two ops in flight, then a stale return
        issue(5'd20, F_REG, 0);
        issue(5'd21, F_REG, 1);
        #1;
        chk("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy",     32'(busy),         0);
        chk("mid_rst_ready",    32'(fpu_ready),    0);
        chk("mid_rst_req",      32'(fpu_req),      0);
        chk("mid_rst_hazard",   32'(hazard_stall), 0);
        chk("mid_rst_wb_valid", 32'(wb_fpu_valid), 0);
        chk("mid_rst_wb_stall", 32'(wb_stall),     0);
        tick();
        rst        = 1'b0;
        fpu_rvalid = 1'b1;
        fpu_tag_in = 2'd0;
        fpu_result = 32'h0BAD0BAD;
        #1;
        chk("stale_ready", 32'(fpu_ready), 1);
        tick();
        fpu_rvalid = 1'b0;
        #1;
        chk("stale_no_wb",   32'(wb_fpu_valid), 0);
        chk("stale_no_busy", 32'(busy),         0);
        tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
